// File: rtl/prog_loader_if.sv
// prog_loader_if: host-side byte stream, start and status plus loader-side imem write port
interface prog_loader_if #(parameter int ADDR_W = 6) ();
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, error
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams count+words+xor checksum into imem, then releases cpu; ports CLK, RST (sync active-low), bus (prog_loader_if.slave)
module prog_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 50000
) (
  input logic        CLK,
  input logic        RST,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;
  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   widx_q;
  logic [1:0]        bidx_q;
  logic [7:0]        n_q, csum_q;
  logic [23:0]       word_q;
  logic [31:0]       timer_q;
  logic              in_ready_q, busy_q, done_q, error_q, cpu_rst_n_q, imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              acc, last, tmo, busy_d;
  always_comb begin
    acc     = bus.in_valid && in_ready_q;
    last    = 32'(widx_q) + 32'd1 == 32'(n_q);
    tmo     = !acc && timer_q == 32'(TIMEOUT - 1);
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = bus.start ? COUNT : state_q;
      COUNT: state_d = tmo ? ERR : !acc ? COUNT : bus.in_data == 8'd0 ? CHECK :
                       32'(bus.in_data) > DEPTH ? ERR : DATA;
      DATA:  state_d = tmo ? ERR : acc && bidx_q == 2'd3 && last ? CHECK : DATA;
      CHECK: state_d = tmo ? ERR : !acc ? CHECK : bus.in_data == csum_q ? DONE : ERR;
      default: state_d = IDLE;
    endcase
    busy_d = state_d == COUNT || state_d == DATA || state_d == CHECK;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      n_q          <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      timer_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= busy_d;
      busy_q      <= busy_d;
      done_q      <= state_d == DONE;
      cpu_rst_n_q <= state_d == DONE;
      error_q     <= state_d == ERR;
      imem_we_q   <= 1'b0;
      if (state_d == COUNT && state_q != COUNT) begin
        widx_q  <= '0;
        bidx_q  <= '0;
        csum_q  <= '0;
        timer_q <= '0;
      end else if (busy_q) begin
        timer_q <= acc ? '0 : timer_q + 32'd1;
        if (acc) begin
          csum_q <= csum_q ^ bus.in_data;
          if (state_q == COUNT) n_q <= bus.in_data;
          if (state_q == DATA) begin
            word_q <= {word_q[15:0], bus.in_data};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= widx_q[ADDR_W-1:0];
              imem_wdata_q <= {word_q, bus.in_data};
              widx_q       <= widx_q + 1'b1;
            end
          end
        end
      end
    end
  end
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader writes, completion, checksum, timeout and reset behaviour
module tb_prog_loader;
  localparam int AW = 6;
  localparam int TO = 20;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int total = 0;
  int bad = 0;
  logic [AW+31:0] exp_q[$];
  prog_loader_if #(.ADDR_W(AW)) bus ();
  prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    logic [AW+31:0] e;
    if (bus.imem_we === 1'b1) begin
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL ready_during_write got=%b want=1", bus.in_ready);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h:%h want=none", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== e) begin
          bad++;
          $display("FAIL write got=%h:%h want=%h:%h", bus.imem_addr, bus.imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] b);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (k == 50) begin
      total++;
      bad++;
      $display("FAIL send_wait got=not_ready want=ready");
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask
  task automatic send_range(input logic [7:0] s[$], input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      send(s[i]);
      if (gap > 0) idle(gap);
    end
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask
  function automatic logic [7:0] xsum(input logic [7:0] s[$]);
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    return x;
  endfunction
  function automatic void push_writes(input logic [7:0] s[$]);
    for (int i = 0; i < int'(s[0]); i++)
      exp_q.push_back({AW'(i), s[4*i+1], s[4*i+2], s[4*i+3], s[4*i+4]});
  endfunction
  function automatic void rand_stream(input int n, output logic [7:0] s[$]);
    s = {};
    s.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(255)));
    s.push_back(xsum(s));
  endfunction
  task automatic test_reset();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({bus.in_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {bus.in_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error});
    end
    total++;
    if ({bus.imem_addr, bus.imem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_bus got=%h:%h want=0:0", bus.imem_addr, bus.imem_wdata);
    end
    pulse_start();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_start got=%b want=0", bus.busy);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask
  task automatic test_good_load();
    logic [7:0] s[$] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    // XOR of the count and payload bytes above is 0x02; that is the matching checksum.
    s.push_back(8'h02);
    exp_q.push_back({6'd0, 32'h12345678});
    exp_q.push_back({6'd1, 32'h9ABCDEF0});
    pulse_start();
    total++;
    if ({bus.busy, bus.in_ready, bus.done, bus.error} !== 4'b1100) begin
      bad++;
      $display("FAIL start_state got=%b want=1100", {bus.busy, bus.in_ready, bus.done, bus.error});
    end
    send_range(s, 0, s.size() - 1, 0);
    total++;
    if ({bus.done, bus.cpu_rst_n, bus.error, bus.busy, bus.in_ready} !== 5'b11000) begin
      bad++;
      $display("FAIL good_end got=%b want=11000", {bus.done, bus.cpu_rst_n, bus.error, bus.busy, bus.in_ready});
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL good_writes_left got=%0d want=0", exp_q.size());
    end
  endtask
  task automatic test_bad_checksum();
    logic [7:0] s[$] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h09};
    exp_q.push_back({6'd0, 32'h12345678});
    exp_q.push_back({6'd1, 32'h9ABCDEF0});
    pulse_start();
    send_range(s, 0, s.size() - 1, 0);
    total++;
    if ({bus.done, bus.cpu_rst_n, bus.error} !== 3'b001) begin
      bad++;
      $display("FAIL bad_sum_end got=%b want=001", {bus.done, bus.cpu_rst_n, bus.error});
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bad_sum_writes_left got=%0d want=0", exp_q.size());
    end
  endtask
  task automatic test_empty_and_oversize();
    logic [7:0] s[$];
    pulse_start();
    send(8'h00);
    send(8'h00);
    total++;
    if ({bus.done, bus.cpu_rst_n, bus.error} !== 3'b110) begin
      bad++;
      $display("FAIL empty_end got=%b want=110", {bus.done, bus.cpu_rst_n, bus.error});
    end
    pulse_start();
    send(8'h41);
    total++;
    if ({bus.done, bus.cpu_rst_n, bus.error, bus.busy} !== 4'b0010) begin
      bad++;
      $display("FAIL oversize_end got=%b want=0010", {bus.done, bus.cpu_rst_n, bus.error, bus.busy});
    end
    rand_stream(64, s);
    push_writes(s);
    pulse_start();
    send_range(s, 0, s.size() - 1, 0);
    total++;
    if ({bus.done, bus.error, exp_q.size() == 0} !== 3'b101) begin
      bad++;
      $display("FAIL full_depth got=%b want=101", {bus.done, bus.error, exp_q.size() == 0});
    end
  endtask
  task automatic test_toggle_and_timeout();
    logic [7:0] s[$];
    rand_stream(2, s);
    push_writes(s);
    pulse_start();
    send_range(s, 0, s.size() - 1, 1);
    total++;
    if ({bus.done, bus.error, exp_q.size() == 0} !== 3'b101) begin
      bad++;
      $display("FAIL toggle_end got=%b want=101", {bus.done, bus.error, exp_q.size() == 0});
    end
    rand_stream(1, s);
    push_writes(s);
    pulse_start();
    send_range(s, 0, 2, 0);
    idle(TO - 1);
    total++;
    if ({bus.busy, bus.error} !== 2'b10) begin
      bad++;
      $display("FAIL stall_short_mid got=%b want=10", {bus.busy, bus.error});
    end
    send_range(s, 3, s.size() - 1, 0);
    total++;
    if ({bus.done, bus.error, exp_q.size() == 0} !== 3'b101) begin
      bad++;
      $display("FAIL stall_short_end got=%b want=101", {bus.done, bus.error, exp_q.size() == 0});
    end
    pulse_start();
    send_range(s, 0, 2, 0);
    idle(TO);
    total++;
    if ({bus.error, bus.busy, bus.done, bus.cpu_rst_n} !== 4'b1000) begin
      bad++;
      $display("FAIL stall_long_end got=%b want=1000", {bus.error, bus.busy, bus.done, bus.cpu_rst_n});
    end
  endtask
  task automatic test_reset_mid_load();
    logic [7:0] s[$];
    rand_stream(2, s);
    exp_q.push_back({6'd0, s[1], s[2], s[3], s[4]});
    pulse_start();
    send_range(s, 0, 5, 0);
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.in_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error} !== 6'b0 ||
        {bus.imem_addr, bus.imem_wdata} !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b:%h:%h want=0:0:0",
               {bus.in_ready, bus.imem_we, bus.cpu_rst_n, bus.busy, bus.done, bus.error},
               bus.imem_addr, bus.imem_wdata);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_writes_left got=%0d want=0", exp_q.size());
    end
    RST = 1'b1;
    idle(3);
    rand_stream(2, s);
    push_writes(s);
    pulse_start();
    send_range(s, 0, s.size() - 1, 0);
    total++;
    if ({bus.done, bus.error, exp_q.size() == 0} !== 3'b101) begin
      bad++;
      $display("FAIL after_reset_load got=%b want=101", {bus.done, bus.error, exp_q.size() == 0});
    end
  endtask
  task automatic test_start_while_busy();
    logic [7:0] s[$];
    rand_stream(2, s);
    push_writes(s);
    pulse_start();
    send_range(s, 0, 6, 0);
    pulse_start();
    total++;
    if ({bus.busy, bus.in_ready, bus.error} !== 3'b110) begin
      bad++;
      $display("FAIL busy_start got=%b want=110", {bus.busy, bus.in_ready, bus.error});
    end
    send_range(s, 7, s.size() - 1, 0);
    total++;
    if ({bus.done, bus.error, exp_q.size() == 0} !== 3'b101) begin
      bad++;
      $display("FAIL busy_start_end got=%b want=101", {bus.done, bus.error, exp_q.size() == 0});
    end
  endtask
  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_empty_and_oversize();
    test_toggle_and_timeout();
    test_reset_mid_load();
    test_start_while_busy();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
